// File: rtl/uart_sram_tx_interface_pkg.sv
// -----------------------------------------------------------------------------
// uart_sram_tx_interface_pkg
// Shared definitions for the UART-to-SRAM transmit path:
//   - tx_state_type  : states of the transmit sequencer
//   - top_state_type : top-level owner of the SRAM port (S_UART_TX selects
//                      this block's address/we_n onto the SRAM controller)
//   - default timing constants and the word-address increment helper
// -----------------------------------------------------------------------------
package uart_sram_tx_interface_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200 baud
  localparam int SRAM_LATENCY_DEFAULT = 2;    // address-to-data cycles
  localparam int ADDR_W               = 18;
  localparam int DATA_W               = 16;

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_ADDR,
    S_TX_WAIT,
    S_TX_CAPTURE,
    S_TX_SEND_HI,
    S_TX_SEND_LO,
    S_TX_DONE
  } tx_state_type;

  typedef enum logic [1:0] {
    S_TOP_IDLE,
    S_UART_RX,
    S_UART_TX
  } top_state_type;

  // Word addresses wrap from 2^18-1 back to 0 through natural 18-bit overflow.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
    return addr + 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// 8N1 byte serialiser: start bit (0), eight data bits LSB first, one stop
// bit (1). Every bit lasts exactly CLKS_PER_BIT cycles, so a frame is
// 10*CLKS_PER_BIT cycles. The line drops low on the cycle after the byte is
// accepted, and o_byte_done pulses in the last cycle of the stop bit.
//
// Handshake: a byte transfers in any cycle where i_byte_valid && o_byte_ready;
// the sender holds i_byte_data stable while i_byte_valid is high.
//
// Ports:
//   i_clock      system clock
//   i_reset      synchronous active-high reset (line returns high)
//   i_byte_data  byte to send
//   i_byte_valid byte offered
//   o_byte_ready serialiser idle, able to accept
//   o_byte_done  single-cycle pulse in the final stop-bit cycle
//   o_tx         serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_byte
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT  // must be >= 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_byte_data,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  output logic       o_byte_done,
  output logic       o_tx
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        IDX_LAST_DATA = 4'd8;
  localparam logic [3:0]        IDX_STOP      = 4'd9;

  logic             r_active;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [3:0]       r_bit_idx;   // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]       r_shift;
  logic             r_tx;

  logic             w_bit_end;

  assign w_bit_end = r_active && (r_baud_cnt == CNT_LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_active   <= 1'b0;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else if (!r_active) begin
      if (i_byte_valid) begin
        r_active   <= 1'b1;
        r_baud_cnt <= '0;
        r_bit_idx  <= '0;
        r_shift    <= i_byte_data;
        r_tx       <= 1'b0;
      end
    end else if (w_bit_end) begin
      r_baud_cnt <= '0;
      if (r_bit_idx == IDX_STOP) begin
        r_active <= 1'b0;
        r_tx     <= 1'b1;
      end else begin
        r_bit_idx <= r_bit_idx + 1'b1;
        if (r_bit_idx == IDX_LAST_DATA) begin
          r_tx <= 1'b1;                      // stop bit
        end else begin
          r_tx    <= r_shift[0];             // next data bit, LSB first
          r_shift <= {1'b0, r_shift[7:1]};
        end
      end
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
    end
  end

  assign o_byte_ready = !r_active;
  assign o_byte_done  = w_bit_end && (r_bit_idx == IDX_STOP);
  assign o_tx         = r_tx;

endmodule

// File: rtl/uart_sram_tx_interface.sv
// -----------------------------------------------------------------------------
// uart_sram_tx_interface
// On a Start pulse, reads Word_count 16-bit words from SRAM beginning at
// Start_address and sends each as two UART 8N1 bytes, high byte first.
// The sequencer only handles SRAM reads; framing lives in uart_tx_byte.
//
// Ports:
//   i_clock          system clock
//   i_reset          synchronous active-high reset
//   i_start          single-cycle start pulse (ignored while busy)
//   i_start_address  first SRAM word address
//   i_word_count     number of words to send (0 = finish immediately)
//   o_sram_address   SRAM read address, held for the whole read
//   i_sram_read_data SRAM read data, valid SRAM_LATENCY cycles after address
//   o_sram_we_n      SRAM write enable (active low), constant 1
//   o_uart_tx        serial line, idle high
//   o_busy           high from the cycle after an accepted start until done
//   o_done           single-cycle completion pulse
//   o_state          current sequencer state (debug visibility)
// -----------------------------------------------------------------------------
module uart_sram_tx_interface
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int SRAM_LATENCY = SRAM_LATENCY_DEFAULT   // must be >= 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_address,
  input  logic [ADDR_W-1:0] i_word_count,
  output logic [ADDR_W-1:0] o_sram_address,
  input  logic [DATA_W-1:0] i_sram_read_data,
  output logic              o_sram_we_n,
  output logic              o_uart_tx,
  output logic              o_busy,
  output logic              o_done,
  output tx_state_type      o_state
);

  localparam int               WAIT_W    = (SRAM_LATENCY > 2) ? $clog2(SRAM_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SRAM_LATENCY - 2);

  tx_state_type      r_state;
  tx_state_type      w_next_state;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remaining;
  logic [ADDR_W-1:0] r_sram_address;
  logic [DATA_W-1:0] r_word;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_byte_sent;   // current byte already handed to serialiser

  logic              w_byte_valid;
  logic [7:0]        w_byte_data;
  logic              w_byte_ready;
  logic              w_byte_done;

  // ---------------------------------------------------------------------------
  // Next-state and serialiser request
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_byte_valid = 1'b0;
    w_byte_data  = 8'h00;
    case (r_state)
      S_TX_IDLE: begin
        if (i_start) begin
          w_next_state = (i_word_count != '0) ? S_TX_ADDR : S_TX_DONE;
        end
      end
      S_TX_ADDR: begin
        w_next_state = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (r_wait_cnt == WAIT_LAST) begin
          w_next_state = S_TX_CAPTURE;
        end
      end
      S_TX_CAPTURE: begin
        w_next_state = S_TX_SEND_HI;
      end
      S_TX_SEND_HI: begin
        w_byte_valid = !r_byte_sent;
        w_byte_data  = r_word[15:8];
        if (w_byte_done) begin
          w_next_state = S_TX_SEND_LO;
        end
      end
      S_TX_SEND_LO: begin
        w_byte_valid = !r_byte_sent;
        w_byte_data  = r_word[7:0];
        if (w_byte_done) begin
          w_next_state = (r_remaining != ADDR_W'(1)) ? S_TX_ADDR : S_TX_DONE;
        end
      end
      S_TX_DONE: begin
        w_next_state = S_TX_IDLE;
      end
      default: begin
        w_next_state = S_TX_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= S_TX_IDLE;
      r_addr         <= '0;
      r_remaining    <= '0;
      r_sram_address <= '0;
      r_word         <= '0;
      r_wait_cnt     <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_byte_sent    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= 1'b0;

      if (w_byte_valid && w_byte_ready) begin
        r_byte_sent <= 1'b1;
      end else if (w_byte_done) begin
        r_byte_sent <= 1'b0;
      end

      case (r_state)
        S_TX_IDLE: begin
          if (i_start) begin
            r_addr      <= i_start_address;
            r_remaining <= i_word_count;
            r_busy      <= 1'b1;
            // The SRAM address register is loaded alongside addr_reg so it
            // already equals addr_reg in S_TX_ADDR and stays put through the
            // read; an empty block leaves the SRAM address untouched.
            if (i_word_count != '0) begin
              r_sram_address <= i_start_address;
            end
          end
        end
        S_TX_ADDR: begin
          r_wait_cnt <= '0;
        end
        S_TX_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
        S_TX_CAPTURE: begin
          r_word <= i_sram_read_data;
        end
        S_TX_SEND_LO: begin
          if (w_byte_done) begin
            r_addr      <= next_addr(r_addr);
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining != ADDR_W'(1)) begin
              r_sram_address <= next_addr(r_addr);
            end
          end
        end
        S_TX_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_byte_data  (w_byte_data),
    .i_byte_valid (w_byte_valid),
    .o_byte_ready (w_byte_ready),
    .o_byte_done  (w_byte_done),
    .o_tx         (o_uart_tx)
  );

  assign o_sram_address = r_sram_address;
  assign o_sram_we_n    = 1'b1;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_state        = r_state;

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
module tb_uart_sram_tx_interface;
  import uart_sram_tx_interface_pkg::*;

  localparam int CLKS = 434;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [17:0]  start_addr;
  logic [17:0]  word_count;
  logic [17:0]  sram_address;
  logic [15:0]  sram_rd;
  logic         we_n;
  logic         tx;
  logic         busy;
  logic         done;
  tx_state_type state;

  always #5 clk = ~clk;

  uart_sram_tx_interface #(
    .CLKS_PER_BIT (CLKS),
    .SRAM_LATENCY (2)
  ) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_start          (start),
    .i_start_address  (start_addr),
    .i_word_count     (word_count),
    .o_sram_address   (sram_address),
    .i_sram_read_data (sram_rd),
    .o_sram_we_n      (we_n),
    .o_uart_tx        (tx),
    .o_busy           (busy),
    .o_done           (done),
    .o_state          (state)
  );

  // SRAM model: two-cycle read latency.
  logic [15:0] mem [logic [17:0]];
  logic [15:0] rd_d1;

  function automatic logic [15:0] sram_lookup(input logic [17:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'hDEAD;
  endfunction

  always @(posedge clk) begin
    rd_d1   <= sram_lookup(sram_address);
    sram_rd <= rd_d1;
  end

  // ---------------------------------------------------------------------------
  // Monitors: done pulses, line falling edges, low-run lengths, address log
  // ---------------------------------------------------------------------------
  int          done_cnt = 0;
  int          fall_cnt = 0;
  int          cur_low  = 0;
  int          low_q[$];
  logic        prev_tx   = 1'b1;
  logic [17:0] prev_addr = '0;
  logic [17:0] addr_log[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (done === 1'b1) done_cnt++;
      if (prev_tx === 1'b1 && tx === 1'b0) fall_cnt++;
      if (sram_address !== prev_addr) addr_log.push_back(sram_address);
      if (tx === 1'b0) begin
        cur_low++;
      end else if (cur_low > 0) begin
        low_q.push_back(cur_low);
        cur_low = 0;
      end
    end
    prev_tx   = tx;
    prev_addr = sram_address;
  end

  // UART receiver: sample each bit at its centre, push {stop, data}.
  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] rx_byte;
  logic       rx_stop;

  always begin
    @(negedge clk);
    if (!rst && tx === 1'b0) begin
      repeat (CLKS / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CLKS) @(negedge clk);
        rx_byte[i] = tx;
      end
      repeat (CLKS) @(negedge clk);
      rx_stop = tx;
      rx_q.push_back({rx_stop, rx_byte});
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      check(tag, {23'd0, rx_q.pop_front()}, {23'd0, exp_q.pop_front()});
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  // Returns with time #1 after the edge that samples start.
  task automatic pulse_start(input logic [17:0] a, input logic [17:0] n);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = a;
    word_count = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts busy-high cycles until done is seen; bounded by budget.
  task automatic wait_done(input int budget, output int busy_cycles, output bit seen);
    busy_cycles = 0;
    seen        = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) busy_cycles++;
    end
  endtask

  // Watchdog
  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  int          bc;
  bit          seen;
  int          base_done;
  int          base_fall;
  int          cnt_a;
  int          cnt_b;
  int          exp_low[8];

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    word_count = '0;
    mem[18'h00010] = 16'hA55A;
    mem[18'h3FFFF] = 16'h1234;
    mem[18'h00000] = 16'h5678;
    mem[18'h00001] = 16'h9ABC;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx",    {31'd0, tx},   32'd1);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_addr",  {14'd0, sram_address}, 32'h0);
    check("rst_we_n",  {31'd0, we_n}, 32'd1);
    check("rst_state", {29'd0, state}, {29'd0, S_TX_IDLE});

    // Idle for 100 cycles
    rst   = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1)   cnt_a++;
      if (busy !== 1'b0) cnt_b++;
      if (we_n !== 1'b1) cnt_b++;
    end
    check("idle_tx_not_high", cnt_a, 0);
    check("idle_busy_or_we",  cnt_b, 0);

    // Single word 0xA55A from 0x00010
    low_q.delete();
    addr_log.delete();
    base_done = done_cnt;
    pulse_start(18'h00010, 18'd1);
    check("t1_busy_set", {31'd0, busy}, 32'd1);
    wait_done(20000, bc, seen);
    check("t1_done_seen", {31'd0, seen}, 32'd1);
    check("t1_busy_cycles", bc, 8686);
    check("t1_busy_at_done", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("t1_done_count", done_cnt - base_done, 1);
    check("t1_nreads", addr_log.size(), 1);
    if (addr_log.size() > 0) check("t1_read_addr", {14'd0, addr_log[0]}, 32'h00010);
    exp_q.push_back({1'b1, 8'hA5});
    exp_q.push_back({1'b1, 8'h5A});
    check_bytes("t1_byte");
    // Low runs: A5 -> start, b1, b3+b4, b6 ; 5A -> start+b0, b2, b5, b7
    exp_low = '{434, 434, 868, 434, 868, 434, 434, 434};
    check("t1_nlow_runs", low_q.size(), 8);
    for (int i = 0; i < 8 && i < low_q.size(); i++) begin
      check($sformatf("t1_low_run%0d", i), low_q[i], exp_low[i]);
    end

    // Three words with address wrap
    addr_log.delete();
    base_done = done_cnt;
    pulse_start(18'h3FFFF, 18'd3);
    wait_done(40000, bc, seen);
    check("t2_done_seen", {31'd0, seen}, 32'd1);
    check("t2_busy_cycles", bc, 26056);
    repeat (5) @(negedge clk);
    check("t2_done_count", done_cnt - base_done, 1);
    check("t2_nreads", addr_log.size(), 3);
    if (addr_log.size() == 3) begin
      check("t2_addr0", {14'd0, addr_log[0]}, 32'h3FFFF);
      check("t2_addr1", {14'd0, addr_log[1]}, 32'h00000);
      check("t2_addr2", {14'd0, addr_log[2]}, 32'h00001);
    end
    exp_q.push_back({1'b1, 8'h12});
    exp_q.push_back({1'b1, 8'h34});
    exp_q.push_back({1'b1, 8'h56});
    exp_q.push_back({1'b1, 8'h78});
    exp_q.push_back({1'b1, 8'h9A});
    exp_q.push_back({1'b1, 8'hBC});
    check_bytes("t2_byte");

    // Zero count: done two cycles after start, nothing else moves
    base_fall = fall_cnt;
    pulse_start(18'h00123, 18'd0);
    @(negedge clk);
    check("t3_c1_done", {31'd0, done}, 32'd0);
    check("t3_c1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t3_c2_done", {31'd0, done}, 32'd1);
    check("t3_c2_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t3_c3_done", {31'd0, done}, 32'd0);
    repeat (20) @(negedge clk);
    check("t3_no_falls", fall_cnt - base_fall, 0);
    check("t3_addr_kept", {14'd0, sram_address}, 32'h00001);

    // Start while busy is ignored
    base_done = done_cnt;
    base_fall = fall_cnt;
    pulse_start(18'h00010, 18'd1);
    repeat (1000) @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = 18'h00020;
    word_count = 18'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(20000, bc, seen);
    check("t4_done_seen", {31'd0, seen}, 32'd1);
    repeat (100) @(negedge clk);
    check("t4_busy_after", {31'd0, busy}, 32'd0);
    check("t4_done_count", done_cnt - base_done, 1);
    check("t4_falls", fall_cnt - base_fall, 8);
    exp_q.push_back({1'b1, 8'hA5});
    exp_q.push_back({1'b1, 8'h5A});
    check_bytes("t4_byte");

    // Reset during bit 3 of the first byte
    base_done = done_cnt;
    pulse_start(18'h3FFFF, 18'd3);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1'b1;
    end
    check("t5_line_dropped", {31'd0, seen}, 32'd1);
    repeat (4 * CLKS + CLKS / 2) @(negedge clk);
    check("t5_mid_bit3_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rst_tx",    {31'd0, tx},   32'd1);
    check("t5_rst_busy",  {31'd0, busy}, 32'd0);
    check("t5_rst_state", {29'd0, state}, {29'd0, S_TX_IDLE});
    rst = 1'b0;
    repeat (10 * CLKS) @(negedge clk);
    check("t5_no_done", done_cnt - base_done, 0);
    rx_q.delete();
    base_done = done_cnt;
    pulse_start(18'h00010, 18'd1);
    wait_done(20000, bc, seen);
    check("t5_restart_done", {31'd0, seen}, 32'd1);
    check("t5_restart_busy_cycles", bc, 8686);
    repeat (5) @(negedge clk);
    check("t5_restart_done_count", done_cnt - base_done, 1);
    exp_q.push_back({1'b1, 8'hA5});
    exp_q.push_back({1'b1, 8'h5A});
    check_bytes("t5_byte");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_sram_tx_interface.md
Name: uart_sram_tx_interface

Overview:
Transmit-side counterpart of the UART-to-SRAM receive path. On a start pulse it reads a block of 16-bit words from external SRAM and serialises each word as two UART 8N1 bytes, high byte first, on UART_TX_O. The top level grants this block the SRAM port while its state is active. It replaces the constant-high tie-off on the TX pin.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud)
SRAM_LATENCY, 2, cycles from SRAM_address driven to SRAM_read_data valid

Ports:
Clock  input  1  50 MHz system clock
Reset  input  1  synchronous, active-high reset
Start  input  1  single-cycle pulse; latches Start_address and Word_count
Start_address  input  18  first SRAM word address
Word_count  input  18  number of 16-bit words to send
SRAM_address  output  18  read address to the SRAM controller
SRAM_read_data  input  16  read data from the SRAM controller
SRAM_we_n  output  1  write enable, active low; constant 1
UART_TX_O  output  1  serial line; idle high
Busy  output  1  high from the cycle after an accepted Start until Done
Done  output  1  single-cycle pulse when the block completes

Behaviour:
- One clock (Clock). Reset is synchronous and active-high.
- Reset values: UART_TX_O=1, Busy=0, Done=0, SRAM_address=0, SRAM_we_n=1. The FSM returns to S_TX_IDLE.
- Reset mid-transfer: the line returns high on the next edge and the partial byte is abandoned. No Done pulse is issued.
- FSM states: S_TX_IDLE, S_TX_ADDR, S_TX_WAIT, S_TX_CAPTURE, S_TX_SEND_HI, S_TX_SEND_LO, S_TX_DONE.
- S_TX_IDLE, on Start=1:
  - latch the address into addr_reg and the count into remaining (18-bit);
  - set Busy=1;
  - go to S_TX_ADDR if Word_count!=0, otherwise to S_TX_DONE.
- Start is ignored while Busy=1.
- S_TX_ADDR: drive SRAM_address=addr_reg, then go to S_TX_WAIT.
- S_TX_WAIT:
  - wait SRAM_LATENCY-1 cycles, then go to S_TX_CAPTURE;
  - SRAM_address is held for the whole read.
- S_TX_CAPTURE: register SRAM_read_data into word_reg, then go to S_TX_SEND_HI.
- S_TX_SEND_HI: present word_reg[15:8] to the serialiser; wait for byte_done, then go to S_TX_SEND_LO.
- S_TX_SEND_LO: present word_reg[7:0] to the serialiser; on byte_done:
  - addr_reg+1 (wraps 2^18-1 -> 0);
  - remaining-1;
  - go to S_TX_ADDR if remaining!=1, otherwise to S_TX_DONE.
- S_TX_DONE: Done=1 for exactly one cycle, Busy=0 in the same cycle, then S_TX_IDLE.
- Serialiser byte frame, 8N1:
  - start bit 0, then data LSB first, then one stop bit 1;
  - each bit lasts exactly CLKS_PER_BIT cycles;
  - a byte takes exactly 10*CLKS_PER_BIT cycles;
  - the line goes low on the cycle after byte_valid is accepted;
  - byte_done pulses in the final cycle of the stop bit.
- The SRAM read for word n+1 starts only after word n's low byte completes. Gap between words is 1+SRAM_LATENCY+1 cycles of idle-high line.
- Word_count=0: no SRAM access, no line activity; Done is asserted 2 cycles after Start.
- Word_count=2^18-1 is legal; the address wraps as above.

Decomposition:
- Shared package (project_pkg / define_state.h):
  - tx_state_type enum with the seven S_TX_* states;
  - CLKS_PER_BIT default constant;
  - S_UART_TX entry in top_state_type for the top-level SRAM mux.
- Sub-module uart_tx_byte:
  - ports: Clock, Reset, byte_data[7:0], byte_valid, byte_ready, byte_done, tx;
  - contents: baud counter, 4-bit bit index, shift register.
- The parent FSM handles SRAM sequencing only.

Test Plan:
- Reset then idle: 100 cycles with no Start -> UART_TX_O=1 throughout, Busy=0, SRAM_we_n=1.
- Single word: SRAM[0x00010]=0xA55A; Start_address=0x00010, Word_count=1; expected response:
  - line carries byte 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), then byte 0x5A;
  - each bit is 434 cycles long;
  - Done pulses once;
  - Busy high for 8680+overhead cycles;
  - SRAM_address=0x00010 during the read.
- Multi-word with wrap:
  - Start_address=0x3FFFF, Word_count=3, SRAM[0x3FFFF]=0x1234, SRAM[0]=0x5678, SRAM[1]=0x9ABC;
  - expected bytes in order: 12 34 56 78 9A BC;
  - addresses read in order: 0x3FFFF, 0x00000, 0x00001.
- Zero count: Word_count=0 -> Done 2 cycles after Start, no line transition, SRAM_address unchanged.
- Start while busy: second Start 1000 cycles into a 1-word transfer -> ignored; exactly 2 bytes are sent and one Done.
- Reset mid-byte: Reset asserted during bit 3 of the first byte -> UART_TX_O=1 and Busy=0 on the next edge, no Done; a following Start works normally.
